bus_cycle_ctrl: RTL and testbench
=================================

BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameters SHALL be as follows, one per line (name, default, meaning):
- IOM, 0, address space this block answers: 0 = memory, 1 = I/O
- ADDR_W, 20, latched address width
- NUM_DEV, 4, number of chip selects; power of two, 2..16
- WAIT_STATES, 1, minimum extra cycles in the data phase
- TIMEOUT, 8, maximum cycles waited for a strobe or for ready; must be at least 1
REQ-003 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clock, in, 1, rising-edge clock
- reset, in, 1, asynchronous active-high reset
- ALE, in, 1, address latch enable
- M_IOb, in, 1, bus space qualifier: 1 = memory, 0 = I/O
- addr, in, ADDR_W, bus address
- rdb, in, 1, read strobe, active-low
- wrb, in, 1, write strobe, active-low
- ready, in, 1, device ready, active-high
- OEb, out, 1, read data-phase enable; high during READ
- WR_RDb, out, 1, write data-phase enable; high during WRITE
- CSb, out, NUM_DEV, one-hot-low chip selects
- busy, out, 1, high in any state except IDLE
- cycle_done, out, 1, one-cycle pulse on normal completion
- timeout_err, out, 1, one-cycle pulse on abort

Function
REQ-004 The state machine SHALL have the states IDLE, DECODE, READ, WRITE and TRISTATE, and SHALL be one-hot encoded.
REQ-005 From IDLE, when ALE=1 is sampled: latch addr and M_IOb, then go to DECODE. Otherwise remain in IDLE.
REQ-006 The space match SHALL be (latched M_IOb == ~IOM).
- Device index = the top log2(NUM_DEV) bits of the latched addr.
- Device index is always valid.
REQ-007 In DECODE with no space match: go to IDLE next cycle, with no CSb asserted and no pulse.
REQ-008 In DECODE with a space match, the strobes SHALL be handled as follows:
- wrb=0 -> WRITE.
- Otherwise rdb=0 -> READ.
- rdb=0 and wrb=0 together -> WRITE (write has priority).
- No strobe -> remain in DECODE.
REQ-009 The DECODE wait counter SHALL count cycles spent in DECODE without a strobe.
- After TIMEOUT such cycles: go to IDLE and pulse timeout_err.
REQ-010 CSb[index] SHALL be 0 from the cycle after a matched DECODE through TRISTATE inclusive. All other CSb bits SHALL be 1.
REQ-011 On entry to READ or WRITE, load the wait-state counter with WAIT_STATES.
- While the counter is non-zero: decrement it; ready is ignored.
- Counter at zero and ready=1: go to TRISTATE next cycle.
REQ-012 With the wait-state counter at zero and ready=0: count cycles.
- After TIMEOUT such cycles: go to TRISTATE and pulse timeout_err in the TRISTATE cycle; no cycle_done.
REQ-013 TRISTATE SHALL last exactly one cycle, then go to IDLE.
- On normal completion, cycle_done=1 during TRISTATE.
REQ-014 ALE asserted outside IDLE SHALL be ignored; a new cycle needs IDLE first.
REQ-015 OEb and WR_RDb SHALL be decoded from the present state only, and are never both 1.
REQ-016 Strobe deassertion during READ/WRITE SHALL NOT shorten the data phase.
REQ-017 Minimum latency SHALL be as follows:
- ALE sampled at edge n -> DECODE at n+1.
- Strobe sampled at n+1 -> READ/WRITE at n+2.
- Data phase of WAIT_STATES+1 cycles.
- Then one TRISTATE cycle.

Reset
REQ-018 reset=1 SHALL immediately force the following, independent of clock:
- State to IDLE; both counters to 0; latched addr to 0.
- OEb=0, WR_RDb=0, CSb all 1s, busy=0, cycle_done=0, timeout_err=0.
REQ-019 Reset asserted mid-cycle SHALL abort the cycle with no cycle_done or timeout_err pulse.
- After reset deassertion, the first state is IDLE.

Verification
REQ-020 Memory read (IOM=0, M_IOb=1, addr=20'hC0000, rdb=0, ready=1) -> the following:
- CSb=4'b0111.
- OEb=1 for exactly 2 cycles.
- cycle_done pulses once.
- Total 5 cycles ALE-to-IDLE.
REQ-021 I/O access while IOM=0 (M_IOb=0, rdb=0) -> DECODE then IDLE, CSb=4'b1111, OEb=0, no pulses.
REQ-022 Simultaneous rdb=0, wrb=0, addr=20'h40000 -> WRITE, WR_RDb=1, OEb=0, CSb=4'b1101.
REQ-023 Write with ready held 0 (TIMEOUT=8, WAIT_STATES=1) -> WR_RDb=1 for 1+8 cycles, then TRISTATE with timeout_err=1, cycle_done=0.
REQ-024 ALE with no strobe for 8 cycles -> IDLE after 8 DECODE cycles, timeout_err pulse, CSb stays 4'b1111.
REQ-025 Reset asserted between edges during READ -> OEb=0 and CSb=4'b1111 before the next clock edge; first state after release is IDLE.

Source files
------------

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - ALE-latched bus cycle controller with chip-select decode and timeouts
module bus_cycle_ctrl #(
    parameter bit IOM         = 1'b0,
    parameter int ADDR_W      = 20,
    parameter int NUM_DEV     = 4,
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ALE,
    input  logic              M_IOb,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rdb,
    input  logic              wrb,
    input  logic              ready,
    output logic              OEb,
    output logic              WR_RDb,
    output logic [NUM_DEV-1:0] CSb,
    output logic              busy,
    output logic              cycle_done,
    output logic              timeout_err
);

    localparam int IDX_W = $clog2(NUM_DEV);
    localparam int WS_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam int I_IDLE   = 0;
    localparam int I_DECODE = 1;
    localparam int I_READ   = 2;
    localparam int I_WRITE  = 3;
    localparam int I_TRI    = 4;

    localparam logic [4:0] ST_IDLE   = 5'b00001;
    localparam logic [4:0] ST_DECODE = 5'b00010;
    localparam logic [4:0] ST_READ   = 5'b00100;
    localparam logic [4:0] ST_WRITE  = 5'b01000;
    localparam logic [4:0] ST_TRI    = 5'b10000;

    localparam logic [WS_W-1:0] WS_LOAD = WS_W'(WAIT_STATES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [4:0]        state_q, state_d;
    logic [WS_W-1:0]   ws_q, ws_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mio_q, mio_d;
    logic              err_q, err_d;

    logic              space_match;
    logic [IDX_W-1:0]  dev_idx;
    logic              cs_active;
    logic              unused_addr_bits;

    assign space_match      = (mio_q == ~IOM);
    assign dev_idx          = addr_q[ADDR_W-1 -: IDX_W];
    assign unused_addr_bits = ^addr_q[ADDR_W-IDX_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ws_q    <= '0;
            to_q    <= '0;
            addr_q  <= '0;
            mio_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ws_q    <= ws_d;
            to_q    <= to_d;
            addr_q  <= addr_d;
            mio_q   <= mio_d;
            err_q   <= err_d;
        end
    end

    // to_q is shared: DECODE strobe wait, then data-phase ready wait.
    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        to_d    = to_q;
        addr_d  = addr_q;
        mio_d   = mio_q;
        err_d   = 1'b0;
        if (state_q[I_IDLE]) begin
            if (ALE) begin
                addr_d  = addr;
                mio_d   = M_IOb;
                to_d    = '0;
                state_d = ST_DECODE;
            end
        end else if (state_q[I_DECODE]) begin
            if (!space_match) begin
                to_d    = '0;
                state_d = ST_IDLE;
            end else if (!wrb) begin
                ws_d    = WS_LOAD;
                to_d    = '0;
                state_d = ST_WRITE;
            end else if (!rdb) begin
                ws_d    = WS_LOAD;
                to_d    = '0;
                state_d = ST_READ;
            end else if (to_q == TO_LAST) begin
                to_d    = '0;
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                to_d = to_q + 1'b1;
            end
        end else if (state_q[I_READ] || state_q[I_WRITE]) begin
            if (ws_q != '0) begin
                ws_d = ws_q - 1'b1;
            end else if (ready) begin
                to_d    = '0;
                state_d = ST_TRI;
            end else if (to_q == TO_LAST) begin
                to_d    = '0;
                err_d   = 1'b1;
                state_d = ST_TRI;
            end else begin
                to_d = to_q + 1'b1;
            end
        end else if (state_q[I_TRI]) begin
            state_d = ST_IDLE;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // err_q marks the cycle after an abort: TRISTATE for data-phase, IDLE for decode.
    always_comb begin
        OEb         = state_q[I_READ];
        WR_RDb      = state_q[I_WRITE];
        busy        = ~state_q[I_IDLE];
        cs_active   = state_q[I_READ] | state_q[I_WRITE] | state_q[I_TRI];
        CSb         = cs_active ? ~(NUM_DEV'(1) << dev_idx) : '1;
        cycle_done  = state_q[I_TRI] & ~err_q;
        timeout_err = err_q;
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - directed self-checking bench for bus_cycle_ctrl
module tb_bus_cycle_ctrl;

    logic        clock;
    logic        reset;
    logic        ALE;
    logic        M_IOb;
    logic [19:0] addr;
    logic        rdb;
    logic        wrb;
    logic        ready;
    logic        OEb;
    logic        WR_RDb;
    logic [3:0]  CSb;
    logic        busy;
    logic        cycle_done;
    logic        timeout_err;

    int checks;
    int errors;

    int       oe_cnt, wr_cnt, done_cnt, err_cnt, err_tri_cnt, cycles;
    logic [3:0] cs_seen;
    bit       cs_multi, finished;

    bus_cycle_ctrl #(
        .IOM(1'b0), .ADDR_W(20), .NUM_DEV(4), .WAIT_STATES(1), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset), .ALE(ALE), .M_IOb(M_IOb), .addr(addr),
        .rdb(rdb), .wrb(wrb), .ready(ready), .OEb(OEb), .WR_RDb(WR_RDb),
        .CSb(CSb), .busy(busy), .cycle_done(cycle_done), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Starts one bus cycle at a negedge and records what the DUT does until it is back in IDLE.
    task automatic run_cycle(input logic mio, input logic [19:0] a, input logic r, input logic w,
                             input logic rdy, input int ready_at, input bit release_strobe,
                             input bit hold_ale);
        oe_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0; err_tri_cnt = 0; cycles = 0;
        cs_seen = 4'hF; cs_multi = 1'b0; finished = 1'b0;
        ALE = 1'b1; M_IOb = mio; addr = a; rdb = r; wrb = w; ready = rdy;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (!hold_ale) ALE = 1'b0;
            cycles++;
            if (OEb) oe_cnt++;
            if (WR_RDb) wr_cnt++;
            if (cycle_done) done_cnt++;
            if (timeout_err) err_cnt++;
            if (timeout_err && busy && !OEb && !WR_RDb) err_tri_cnt++;
            if (CSb !== 4'hF) begin
                if (cs_seen !== 4'hF && cs_seen !== CSb) cs_multi = 1'b1;
                cs_seen = CSb;
            end
            if (ready_at > 0 && (oe_cnt + wr_cnt) == ready_at) ready = 1'b1;
            if (release_strobe && (OEb || WR_RDb)) begin
                rdb = 1'b1; wrb = 1'b1;
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        ALE = 1'b0; rdb = 1'b1; wrb = 1'b1; ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ALE = 1'b0; M_IOb = 1'b1; addr = '0; rdb = 1'b1; wrb = 1'b1; ready = 1'b1;
        #3;
        checks++;
        if ({OEb, WR_RDb, busy, cycle_done, timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 00000", {OEb, WR_RDb, busy, cycle_done, timeout_err});
        end
        checks++;
        if (CSb !== 4'hF) begin
            errors++;
            $display("FAIL reset_csb got %b expected 1111", CSb);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle busy got %b expected 0", busy);
        end
    endtask

    task automatic test_mem_read();
        run_cycle(1'b1, 20'hC0000, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        checks++;
        if (!finished) begin errors++; $display("FAIL rd_finished got 0 expected 1"); end
        checks++;
        if (cs_seen !== 4'b0111 || cs_multi) begin
            errors++; $display("FAIL rd_csb got %b multi %0d expected 0111", cs_seen, cs_multi);
        end
        checks++;
        if (oe_cnt !== 2) begin errors++; $display("FAIL rd_oe_cycles got %0d expected 2", oe_cnt); end
        checks++;
        if (wr_cnt !== 0) begin errors++; $display("FAIL rd_wr_cycles got %0d expected 0", wr_cnt); end
        checks++;
        if (done_cnt !== 1 || err_cnt !== 0) begin
            errors++; $display("FAIL rd_pulses got done %0d err %0d expected 1 0", done_cnt, err_cnt);
        end
        checks++;
        if (cycles !== 5) begin errors++; $display("FAIL rd_latency got %0d expected 5", cycles); end
    endtask

    task automatic test_io_mismatch();
        run_cycle(1'b0, 20'hC0000, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        checks++;
        if (cycles !== 2 || !finished) begin
            errors++; $display("FAIL io_cycles got %0d expected 2", cycles);
        end
        checks++;
        if (cs_seen !== 4'hF || oe_cnt !== 0 || wr_cnt !== 0) begin
            errors++; $display("FAIL io_outputs got cs %b oe %0d wr %0d expected 1111 0 0", cs_seen, oe_cnt, wr_cnt);
        end
        checks++;
        if (done_cnt !== 0 || err_cnt !== 0) begin
            errors++; $display("FAIL io_pulses got done %0d err %0d expected 0 0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_write_priority();
        run_cycle(1'b1, 20'h40000, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        checks++;
        if (wr_cnt !== 2 || oe_cnt !== 0) begin
            errors++; $display("FAIL wp_phase got wr %0d oe %0d expected 2 0", wr_cnt, oe_cnt);
        end
        checks++;
        if (cs_seen !== 4'b1101 || cs_multi) begin
            errors++; $display("FAIL wp_csb got %b expected 1101", cs_seen);
        end
        checks++;
        if (done_cnt !== 1 || cycles !== 5) begin
            errors++; $display("FAIL wp_done got done %0d cycles %0d expected 1 5", done_cnt, cycles);
        end
    endtask

    task automatic test_write_timeout();
        run_cycle(1'b1, 20'h80000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (wr_cnt !== 9) begin errors++; $display("FAIL wto_wr_cycles got %0d expected 9", wr_cnt); end
        checks++;
        if (err_tri_cnt !== 1 || err_cnt !== 1) begin
            errors++; $display("FAIL wto_err got tri %0d total %0d expected 1 1", err_tri_cnt, err_cnt);
        end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL wto_done got %0d expected 0", done_cnt); end
        checks++;
        if (cycles !== 12 || cs_seen !== 4'b1011) begin
            errors++; $display("FAIL wto_shape got cycles %0d cs %b expected 12 1011", cycles, cs_seen);
        end
    endtask

    task automatic test_decode_timeout();
        run_cycle(1'b1, 20'hC0000, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        checks++;
        if (cycles !== 9 || !finished) begin
            errors++; $display("FAIL dto_cycles got %0d expected 9", cycles);
        end
        checks++;
        if (err_cnt !== 1 || done_cnt !== 0) begin
            errors++; $display("FAIL dto_pulses got err %0d done %0d expected 1 0", err_cnt, done_cnt);
        end
        checks++;
        if (cs_seen !== 4'hF) begin errors++; $display("FAIL dto_csb got %b expected 1111", cs_seen); end
        @(negedge clock);
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL dto_after got err %b busy %b expected 0 0", timeout_err, busy);
        end
    endtask

    task automatic test_ready_wait();
        run_cycle(1'b1, 20'h00000, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0);
        checks++;
        if (oe_cnt !== 4 || done_cnt !== 1 || err_cnt !== 0) begin
            errors++; $display("FAIL rw_phase got oe %0d done %0d err %0d expected 4 1 0", oe_cnt, done_cnt, err_cnt);
        end
        checks++;
        if (cs_seen !== 4'b1110) begin errors++; $display("FAIL rw_csb got %b expected 1110", cs_seen); end
    endtask

    task automatic test_strobe_release();
        run_cycle(1'b1, 20'hC0000, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        checks++;
        if (oe_cnt !== 2 || done_cnt !== 1) begin
            errors++; $display("FAIL sr_phase got oe %0d done %0d expected 2 1", oe_cnt, done_cnt);
        end
    endtask

    task automatic test_ale_ignored();
        run_cycle(1'b1, 20'h40000, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        checks++;
        if (oe_cnt !== 2 || cycles !== 5 || done_cnt !== 1) begin
            errors++; $display("FAIL ale_ign got oe %0d cycles %0d done %0d expected 2 5 1", oe_cnt, cycles, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        run_cycle(1'b1, 20'h00000, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        checks++;
        if (cs_seen !== 4'b1110 || oe_cnt !== 2) begin
            errors++; $display("FAIL b2b_first got cs %b oe %0d expected 1110 2", cs_seen, oe_cnt);
        end
        run_cycle(1'b1, 20'h80000, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        checks++;
        if (cs_seen !== 4'b1011 || wr_cnt !== 2 || cycles !== 5) begin
            errors++; $display("FAIL b2b_second got cs %b wr %0d cycles %0d expected 1011 2 5", cs_seen, wr_cnt, cycles);
        end
    endtask

    task automatic test_reset_mid_read();
        int pulses;
        ALE = 1'b1; M_IOb = 1'b1; addr = 20'hC0000; rdb = 1'b0; wrb = 1'b1; ready = 1'b0;
        @(negedge clock);
        ALE = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (OEb !== 1'b1) begin errors++; $display("FAIL rst_pre_oe got %b expected 1", OEb); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (OEb !== 1'b0 || CSb !== 4'hF || busy !== 1'b0) begin
            errors++; $display("FAIL rst_async got oe %b cs %b busy %b expected 0 1111 0", OEb, CSb, busy);
        end
        checks++;
        if (cycle_done !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL rst_async_pulses got done %b err %b expected 0 0", cycle_done, timeout_err);
        end
        rdb = 1'b1; ready = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (busy || cycle_done || timeout_err) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL rst_after got %0d active cycles expected 0", pulses);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mem_read();
        test_io_mismatch();
        test_write_priority();
        test_write_timeout();
        test_decode_timeout();
        test_ready_wait();
        test_strobe_release();
        test_ale_ignored();
        test_back_to_back();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
